// File: rtl/qos_pkg.sv
// Shared types and helpers for the QoS measurement-window scheduler.
// Lane extraction and alarm test for the packed per-stream counter bus.
package qos_pkg;

  localparam int NUM_STREAMS = 4;
  localparam int CC_CNT_W    = 8;
  localparam int BUS_W       = NUM_STREAMS * CC_CNT_W;

  typedef enum logic {IDLE, COUNT} win_state_t;
  typedef enum logic {R_IDLE, R_SEND} rpt_state_t;

  function automatic logic [CC_CNT_W-1:0] lane(
    input logic [BUS_W-1:0] bus,
    input int               i
  );
    return bus[i*CC_CNT_W +: CC_CNT_W];
  endfunction

  function automatic logic hits(
    input logic [CC_CNT_W-1:0] cnt,
    input logic [CC_CNT_W-1:0] thr
  );
    return (thr != '0) && (cnt >= thr);
  endfunction

endpackage

// File: rtl/qos_window_timer.sv
// Loadable window down-counter with length clamp.
// expire marks the final cycle of a window (count == 1).
module qos_window_timer #(
  parameter int WIN_W      = 32,
  parameter int MIN_WINDOW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             stop,
  input  logic [WIN_W-1:0] len,
  output logic             expire
);

  localparam logic [WIN_W-1:0] MIN_LEN = WIN_W'(MIN_WINDOW);

  logic [WIN_W-1:0] cnt;
  logic [WIN_W-1:0] len_c;

  assign len_c  = (len < MIN_LEN) ? MIN_LEN : len;
  assign expire = (cnt == WIN_W'(1));

  // Down-count, reload at window (re)start, park at zero when stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (stop) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len_c;
    end else if (cnt != '0) begin
      cnt <= cnt - WIN_W'(1);
    end
  end

endmodule

// File: rtl/qos_window_scheduler.sv
// Measurement-window controller for the 4-stream loss counters.
// Times windows, clears counters, snapshots and serializes counts.
module qos_window_scheduler
  import qos_pkg::*;
#(
  parameter int WIN_W      = 32,
  parameter int MIN_WINDOW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic [7:0]       alarm_threshold,
  input  logic             alarm_clr,
  input  logic [31:0]      error_count,
  output logic             en_reset_counter,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [1:0]       rpt_stream,
  output logic [7:0]       rpt_count,
  output logic             rpt_alarm,
  output logic             rpt_last,
  output logic [3:0]       alarm,
  output logic             overrun
);

  win_state_t win_q;
  rpt_state_t rpt_q;

  logic                win_end;
  logic                expire;
  logic                tmr_load;
  logic                tmr_stop;
  logic                snap_load;
  logic                ovr_set;
  logic [3:0]          alarm_set;
  logic [1:0]          nxt;
  logic [CC_CNT_W-1:0] snap [NUM_STREAMS];
  logic [CC_CNT_W-1:0] snap_thr;

  assign win_end   = (win_q == COUNT) && enable && expire;
  assign tmr_load  = ((win_q == IDLE) && enable) || win_end;
  assign tmr_stop  = (win_q == COUNT) && !enable;
  assign snap_load = win_end && (rpt_q == R_IDLE);
  assign ovr_set   = win_end && (rpt_q == R_SEND);
  assign nxt       = rpt_stream + 2'd1;

  qos_window_timer #(
    .WIN_W      (WIN_W),
    .MIN_WINDOW (MIN_WINDOW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .stop   (tmr_stop),
    .len    (window_len),
    .expire (expire)
  );

  // Streams crossing the threshold in the sample being loaded.
  always_comb begin
    alarm_set = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      alarm_set[i] = snap_load &&
                     hits(lane(error_count, i), alarm_threshold);
    end
  end

  // Window FSM: start/end-of-window counter clear pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q            <= IDLE;
      en_reset_counter <= 1'b0;
    end else begin
      unique case (win_q)
        IDLE: begin
          en_reset_counter <= enable;
          if (enable) win_q <= COUNT;
        end
        COUNT: begin
          en_reset_counter <= win_end;
          if (!enable) win_q <= IDLE;
        end
      endcase
    end
  end

  // Report FSM: snapshot at window end, then stream out 0..3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q      <= R_IDLE;
      rpt_valid  <= 1'b0;
      rpt_stream <= '0;
      rpt_count  <= '0;
      rpt_alarm  <= 1'b0;
      rpt_last   <= 1'b0;
      snap_thr   <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) snap[i] <= '0;
    end else begin
      unique case (rpt_q)
        R_IDLE: begin
          if (snap_load) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
              snap[i] <= lane(error_count, i);
            end
            snap_thr   <= alarm_threshold;
            rpt_q      <= R_SEND;
            rpt_valid  <= 1'b1;
            rpt_stream <= 2'd0;
            rpt_count  <= lane(error_count, 0);
            rpt_alarm  <= hits(lane(error_count, 0), alarm_threshold);
            rpt_last   <= 1'b0;
          end
        end
        R_SEND: begin
          if (rpt_ready) begin
            if (rpt_last) begin
              rpt_q     <= R_IDLE;
              rpt_valid <= 1'b0;
              rpt_alarm <= 1'b0;
              rpt_last  <= 1'b0;
            end else begin
              rpt_stream <= nxt;
              rpt_count  <= snap[nxt];
              rpt_alarm  <= hits(snap[nxt], snap_thr);
              rpt_last   <= (nxt == 2'd3);
            end
          end
        end
      endcase
    end
  end

  // Sticky alarm/overrun flags; a same-cycle set wins over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm   <= '0;
      overrun <= 1'b0;
    end else begin
      alarm   <= (alarm_clr ? 4'b0 : alarm) | alarm_set;
      overrun <= (overrun & ~alarm_clr) | ovr_set;
    end
  end

endmodule

// File: tb/tb_qos_window_scheduler.sv
// Self-checking bench for qos_window_scheduler.
// Reference model: window start/length arithmetic plus an entry queue.
module tb_qos_window_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] window_len;
  logic [7:0]  alarm_threshold;
  logic        alarm_clr;
  logic [31:0] error_count;
  logic        en_reset_counter;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [1:0]  rpt_stream;
  logic [7:0]  rpt_count;
  logic        rpt_alarm;
  logic        rpt_last;
  logic [3:0]  alarm;
  logic        overrun;

  qos_window_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .window_len       (window_len),
    .alarm_threshold  (alarm_threshold),
    .alarm_clr        (alarm_clr),
    .error_count      (error_count),
    .en_reset_counter (en_reset_counter),
    .rpt_valid        (rpt_valid),
    .rpt_ready        (rpt_ready),
    .rpt_stream       (rpt_stream),
    .rpt_count        (rpt_count),
    .rpt_alarm        (rpt_alarm),
    .rpt_last         (rpt_last),
    .alarm            (alarm),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] s;
    logic [7:0] c;
    logic       a;
    logic       l;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   npulse;
  ent_t rq[$];
  bit   m_run;
  int   m_start;
  int   m_len;
  logic m_erc;
  logic [3:0] m_alarm;
  logic m_ovr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampl(input logic [31:0] l);
    return (l < 32'd2) ? 2 : int'(l);
  endfunction

  task automatic model_reset();
    rq.delete();
    m_run   = 0;
    m_erc   = 1'b0;
    m_alarm = '0;
    m_ovr   = 1'b0;
  endtask

  // Predict outputs of the next cycle from this cycle's inputs.
  task automatic predict();
    logic [3:0] set;
    logic [7:0] c;
    logic       a;
    bit         busy;
    bit         oset;
    set   = '0;
    oset  = 0;
    m_erc = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    busy = (rq.size() != 0);
    if (busy && rpt_ready) void'(rq.pop_front());
    if (!m_run) begin
      if (enable) begin
        m_run   = 1;
        m_start = cyc + 1;
        m_len   = clampl(window_len);
        m_erc   = 1'b1;
      end
    end else if (!enable) begin
      m_run = 0;
    end else if (cyc == m_start + m_len - 1) begin
      m_erc   = 1'b1;
      m_start = cyc + 1;
      m_len   = clampl(window_len);
      if (!busy) begin
        for (int i = 0; i < 4; i++) begin
          c = error_count[8*i +: 8];
          a = (alarm_threshold != 0) && (c >= alarm_threshold);
          set[i] = a;
          rq.push_back('{s: 2'(i), c: c, a: a, l: (i == 3)});
        end
      end else begin
        oset = 1;
      end
    end
    m_alarm = (alarm_clr ? 4'b0 : m_alarm) | set;
    m_ovr   = (alarm_clr ? 1'b0 : m_ovr) | oset;
  endtask

  task automatic compare();
    chk("erc", 32'(en_reset_counter), 32'(m_erc));
    chk("valid", 32'(rpt_valid), 32'(rq.size() != 0));
    if (rq.size() != 0) begin
      chk("stream", 32'(rpt_stream), 32'(rq[0].s));
      chk("count", 32'(rpt_count), 32'(rq[0].c));
      chk("ralarm", 32'(rpt_alarm), 32'(rq[0].a));
      chk("last", 32'(rpt_last), 32'(rq[0].l));
    end
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    #1;
    compare();
    cyc++;
    if (en_reset_counter) npulse++;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    reset           = 1'b1;
    enable          = 1'b0;
    window_len      = 32'd10;
    error_count     = 32'h04030201;
    alarm_threshold = 8'd3;
    rpt_ready       = 1'b1;
    alarm_clr       = 1'b0;
    cyc             = 0;
    npulse          = 0;
    model_reset();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    cyc   = 0;

    // Basic windowing, report order, alarms, clear vs set.
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      alarm_clr = (cyc == 20) || (cyc == 25);
      step();
      if (cyc == 1)  chk("a_start", 32'(en_reset_counter), 32'd1);
      if (cyc == 11) begin
        chk("a_p11", 32'(en_reset_counter), 32'd1);
        chk("a_e0", 32'(rpt_count), 32'd1);
      end
      if (cyc == 14) begin
        chk("a_e3_cnt", 32'(rpt_count), 32'd4);
        chk("a_e3_last", 32'(rpt_last), 32'd1);
      end
      if (cyc == 15) chk("a_alarm", 32'(alarm), 32'hc);
      if (cyc == 21) chk("a_setwins", 32'(alarm), 32'hc);
      if (cyc == 26) chk("a_clr", 32'(alarm), 32'h0);
    end
    alarm_clr = 1'b0;

    // Backpressure: overrun while windows keep clearing.
    rpt_ready  = 1'b0;
    window_len = 32'd8;
    error_count = 32'h0a0b0c0d;
    npulse = 0;
    repeat (20) step();
    chk("b_ovr", 32'(overrun), 32'd1);
    chk("b_pulses", 32'(npulse >= 2), 32'd1);
    rpt_ready = 1'b1;
    repeat (10) step();

    // Clamped window, then enable dropped.
    alarm_clr  = 1'b1;
    window_len = 32'd0;
    step();
    alarm_clr = 1'b0;
    repeat (9) step();
    enable = 1'b0;
    npulse = 0;
    repeat (15) step();
    chk("c_nopulse", 32'(npulse), 32'd0);
    chk("c_idle", 32'(rpt_valid), 32'd0);

    // Asynchronous reset during a report.
    alarm_threshold = 8'd1;
    error_count     = 32'h05050505;
    window_len      = 32'd6;
    enable          = 1'b1;
    found           = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rq.size() != 0 && rq[0].s == 2'd2) begin
        found = 1;
        break;
      end
    end
    chk("d_reach", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("d_valid", 32'(rpt_valid), 32'd0);
    chk("d_erc", 32'(en_reset_counter), 32'd0);
    chk("d_alarm", 32'(alarm), 32'd0);
    chk("d_ovr", 32'(overrun), 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    step();
    chk("d_restart", 32'(en_reset_counter), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) == 0) window_len = $urandom_range(0, 12);
      error_count = $urandom;
      alarm_threshold = ($urandom_range(0, 3) == 0) ? 8'd0 :
                        8'($urandom_range(0, 255));
      rpt_ready = ($urandom_range(0, 3) != 0);
      alarm_clr = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
